// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared RV32M encodings, FSM states and operand-signedness helpers.
// Provides: XLEN_DEF, F7_MULDIV, funct3_e (F3_MUL..F3_REMU), md_state_e (MD_IDLE..MD_DONE),
//           is_div(), a_signed(), b_signed().
package muldiv_sequencer_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_PREP = 3'd1,
        MD_CALC = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    function automatic logic is_div(funct3_e f);
        return f[2];
    endfunction

    function automatic logic a_signed(funct3_e f);
        return f inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic b_signed(funct3_e f);
        return f inside {F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle between decode/EX and the mul/div sequencer.
// Signals: start, flush, funct3, rs1, rs2 (requester -> sequencer); stall, done, result (sequencer -> requester).
// Modports: master = requester side, slave = sequencer side.
interface muldiv_sequencer_if #(parameter int XLEN = 32);

    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, flush, funct3, rs1, rs2, input stall, done, result);
    modport slave  (input start, flush, funct3, rs1, rs2, output stall, done, result);

endinterface

// File: rtl/muldiv_sequencer_step.sv
// muldiv_step: one combinational iteration of the shared shift-add multiply / restoring divide datapath.
// Ports: acc_i  - current {carry/rem-msb, hi, lo} accumulator (2*XLEN+1 bits)
//        op_i   - multiplicand (multiply) or divisor (divide), already made non-negative
//        div_i  - 1 selects divide step, 0 selects multiply step
//        acc_o  - accumulator after this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN:0] acc_i,
    input  logic [XLEN-1:0] op_i,
    input  logic            div_i,
    output logic [2*XLEN:0] acc_o
);

    logic [XLEN:0]   sum;
    logic [2*XLEN:0] sh;
    logic [XLEN+1:0] diff;

    // Multiply: hi += lsb ? op : 0, then shift {carry,hi,lo} right; the multiplier drains out of lo.
    assign sum  = acc_i[2*XLEN:XLEN] + (acc_i[0] ? {1'b0, op_i} : '0);
    // Divide: shift {rem,quot} left, trial-subtract; a clear borrow bit keeps the difference and sets the quotient bit.
    assign sh   = {acc_i[2*XLEN-1:0], 1'b0};
    assign diff = {1'b0, sh[2*XLEN:XLEN]} - {2'b0, op_i};

    assign acc_o = div_i ? (diff[XLEN+1] ? sh : {diff[XLEN:0], sh[XLEN-1:1], 1'b1})
                         : {1'b0, sum, acc_i[XLEN-1:1]};

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the EX ALU.
// Ports: clk  - rising-edge clock
//        rst  - synchronous active-low reset
//        bus  - muldiv_sequencer_if.slave: start/flush/funct3/rs1/rs2 in; stall/done/result out
// Latency: start in cycle 0 -> done in cycle XLEN+3; divide-by-zero and signed overflow finish in cycle 1.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input logic             clk,
    input logic             rst,
    muldiv_sequencer_if.slave bus
);

    localparam int CW = $clog2(XLEN);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    funct3_e         f3_q, f3_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2*XLEN:0] acc_q, acc_d, acc_step;
    logic            neg_q, neg_d;

    funct3_e           f3_in;
    logic              dz, ovf, sa, sb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qr, divres;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc_i (acc_q),
        .op_i  (b_q),
        .div_i (is_div(f3_q)),
        .acc_o (acc_step)
    );

    assign f3_in = funct3_e'(bus.funct3);
    assign dz    = is_div(f3_in) && bus.rs2 == '0;
    assign ovf   = f3_in inside {F3_DIV, F3_REM} && bus.rs1 == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2 == '1;
    assign sa    = a_signed(f3_q) & a_q[XLEN-1];
    assign sb    = b_signed(f3_q) & b_q[XLEN-1];

    // Quotient lives in the low half, remainder in the high half once the divide loop completes.
    assign prod   = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
    assign qr     = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign divres = neg_q ? -qr : qr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        res_d   = res_q;
        case (state_q)
            MD_IDLE: begin
                if (bus.start && !bus.flush) begin
                    f3_d = f3_in;
                    a_d  = bus.rs1;
                    b_d  = bus.rs2;
                    if (dz || ovf) begin
                        // f3[1] separates REM* from DIV*
                        res_d   = dz ? (f3_in[1] ? bus.rs1 : '1) : (f3_in[1] ? '0 : bus.rs1);
                        state_d = MD_DONE;
                    end else begin
                        state_d = MD_PREP;
                    end
                end
            end
            MD_PREP: begin
                acc_d   = {{(XLEN+1){1'b0}}, sa ? -a_q : a_q};
                b_d     = sb ? -b_q : b_q;
                // Remainder takes the dividend's sign; everything else the product/quotient sign.
                neg_d   = (f3_q == F3_REM) ? sa : sa ^ sb;
                cnt_d   = '0;
                state_d = MD_CALC;
            end
            MD_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) state_d = MD_FIX;
            end
            MD_FIX: begin
                res_d   = is_div(f3_q) ? divres : (f3_q == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
                state_d = MD_DONE;
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (bus.flush && state_q != MD_IDLE) begin
            state_d = MD_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            f3_q    <= F3_MUL;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    // Combinational so the requesting instruction is held in its own start cycle; low in DONE so it retires.
    assign bus.stall  = (state_q == MD_IDLE && bus.start && !bus.flush) || state_q inside {MD_PREP, MD_CALC, MD_FIX};
    assign bus.done   = state_q == MD_DONE;
    assign bus.result = res_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M extension: controls one iterative shift-add/restore datapath for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the ALU in EX. Decode raises start for OP-type instructions with funct7=0000001.
- Stalls the pipeline while an operation is in flight and returns an XLEN-bit result with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the clock edge)
- start  in  1  request; sampled only in IDLE
- flush  in  1  abort current op (branch mispredict/trap); priority over start
- funct3  in  3  RV32M operation select (000 MUL … 111 REMU)
- rs1  in  XLEN  operand A, sampled with start
- rs2  in  XLEN  operand B, sampled with start
- stall  out  1  hold IF/ID/EX registers
- done  out  1  result valid, one-cycle pulse
- result  out  XLEN  operation result, held until next accepted start

Behaviour:
- Reset (rst=0 at edge): state=IDLE, counter=0, done=0, result=0, internal operand/accumulator registers=0. Overrides flush and start. Reset mid-operation aborts with no done.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE + start, normal op:
  - Latch funct3/rs1/rs2.
  - Next state PREP.
- IDLE + start, special-case divide: go directly to DONE (fast path, done one cycle after start).
  - Divide by zero (rs2=0): DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- PREP (1 cycle):
  - Take absolute values per signedness: MULH/DIV/REM both signed; MULHSU rs1 signed only; unsigned variants none.
  - Record result sign.
  - Clear 2*XLEN accumulator; counter=0.
- CALC (XLEN cycles):
  - One iteration per cycle; counter increments.
  - Exit to FIX when counter==XLEN-1 completes.
  - Multiply: add-if-lsb then shift right.
  - Divide: restoring shift-subtract, quotient bit = no-borrow.
- FIX (1 cycle): negate if the recorded sign requires it, then select the result part.
  - MUL: low XLEN bits.
  - MULH*: high XLEN bits.
  - DIV*: quotient.
  - REM*: remainder. Remainder sign follows the dividend.
- DONE (1 cycle): done=1, result updated; next state IDLE.
- Normal latency: start at cycle 0 → done at cycle XLEN+3 (35 for XLEN=32).
- stall = (IDLE & start & !flush) | PREP | CALC | FIX. It is combinational so the requesting instruction is held in the start cycle. It is low in DONE so the instruction retires with the result.
- start outside IDLE is ignored; no queuing.
- start in DONE is not accepted; it is accepted the following cycle in IDLE.
- flush in any non-IDLE state: next state IDLE, done stays 0, result unchanged.
- flush in IDLE with start: request dropped, stall=0.
- All arithmetic is modulo 2^XLEN; the accumulator is 2*XLEN+1 bits wide to keep the divide borrow.

Decomposition:
- defines.v gains:
  - `F3_MUL … `F3_REMU funct3 codes.
  - `F7_MULDIV = 7'b0000001.
  - MULDIV state encodings `MD_IDLE … `MD_DONE.
- Sub-module muldiv_step: purely combinational single iteration. Inputs: accumulator, divisor/multiplicand, mode. Outputs: next accumulator.
- The sequencer owns the FSM, counter, sign handling and special cases.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) → stall high cycles 0–34, done at cycle 35, result=0xFFFFFFEB. MULH same operands → 0xFFFFFFFF.
- MULHU rs1=rs2=0xFFFFFFFF → 0xFFFFFFFE. MULHSU rs1=-1, rs2=2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each with done at cycle 35.
- DIVU rs2=0 → 0xFFFFFFFF with done at cycle 1. REM rs1=5, rs2=0 → 5. DIV 0x80000000/−1 → 0x80000000, done at cycle 1.
- flush asserted at cycle 10 of a DIV → IDLE at cycle 11, no done pulse, result keeps prior value. New start at cycle 12 is accepted normally.
- rst=0 at cycle 20 of a MUL → all outputs 0 next cycle. start while busy (cycle 5) ignored; only one done pulse is produced.
